// File: rtl/rv_wb_pkg.sv
// Shared types and constants for the Wishbone load/store initiator.
package rv_wb_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

    localparam logic [3:0] WB_SEL_ALL = 4'hF;

endpackage

// File: rtl/wb_lane_align.sv
// Byte-lane steering for the LSU: size/offset to select and replicated store
// data, alignment check, and right-justified, extended load data.
module wb_lane_align
    import rv_wb_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_offset,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_sel,
    output logic [31:0] o_wdata,
    output logic        o_misalign,
    output logic [31:0] o_rdata
);

    logic [31:0] shifted;

    always_comb begin
        shifted    = i_rdata >> {i_offset, 3'b000};
        o_sel      = 4'b0000;
        o_wdata    = i_wdata;
        o_misalign = 1'b0;
        o_rdata    = '0;
        case (i_size)
            SZ_BYTE: begin
                o_sel   = 4'b0001 << i_offset;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = i_unsigned ? {24'b0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                o_misalign = i_offset[0];
                o_sel      = 4'b0011 << i_offset;
                o_wdata    = {2{i_wdata[15:0]}};
                o_rdata    = i_unsigned ? {16'b0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
            end
            SZ_WORD: begin
                o_misalign = |i_offset;
                o_sel      = WB_SEL_ALL;
                // Offset is zero whenever a word access is legal, so this is the raw word.
                o_rdata    = shifted;
            end
            default: o_misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_lsu_master.sv
// Wishbone classic initiator for one outstanding core load/store.
// Optional ack watchdog enabled by defining WB_TIMEOUT_EN.
module wb_lsu_master
    import rv_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned TIMEOUT_WIDTH  = 8
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_we,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic [31:0] o_wb_addr,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [3:0]  o_wb_sel,
    output logic [31:0] o_wb_wdata,
    input  logic        i_wb_ack,
    input  logic [31:0] i_wb_rdata
);

    if (TIMEOUT_CYCLES < 2 || (64'd1 << TIMEOUT_WIDTH) <= 64'(TIMEOUT_CYCLES)) begin : g_param_check
        $error("wb_lsu_master: TIMEOUT_CYCLES must be >= 2 and fit in TIMEOUT_WIDTH bits");
    end

    lsu_state_t  state_q, state_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        wb_cyc_q, wb_cyc_d;
    logic        wb_we_q, wb_we_d;
    logic [31:0] wb_addr_q, wb_addr_d;
    logic [3:0]  wb_sel_q, wb_sel_d;
    logic [31:0] wb_wdata_q, wb_wdata_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
`ifdef WB_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
`endif

    logic [1:0]  align_size;
    logic [1:0]  align_off;
    logic        align_uns;
    logic [3:0]  align_sel;
    logic [31:0] align_wdata;
    logic        align_misalign;
    logic [31:0] align_rdata;

    // In IDLE the aligner decodes the incoming request; afterwards it works on the latched copy.
    assign align_size = (state_q == IDLE) ? i_req_size          : size_q;
    assign align_off  = (state_q == IDLE) ? i_req_addr[1:0]     : off_q;
    assign align_uns  = (state_q == IDLE) ? i_req_unsigned      : uns_q;

    wb_lane_align u_align (
        .i_size     (align_size),
        .i_offset   (align_off),
        .i_unsigned (align_uns),
        .i_wdata    (i_req_wdata),
        .i_rdata    (i_wb_rdata),
        .o_sel      (align_sel),
        .o_wdata    (align_wdata),
        .o_misalign (align_misalign),
        .o_rdata    (align_rdata)
    );

    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        size_d      = size_q;
        uns_d       = uns_q;
        wb_cyc_d    = wb_cyc_q;
        wb_we_d     = wb_we_q;
        wb_addr_d   = wb_addr_q;
        wb_sel_d    = wb_sel_q;
        wb_wdata_d  = wb_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef WB_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (i_req_valid) begin
                    off_d  = i_req_addr[1:0];
                    size_d = i_req_size;
                    uns_d  = i_req_unsigned;
                    if (align_misalign) begin
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                        state_d     = RESP;
                    end else begin
                        wb_cyc_d   = 1'b1;
                        wb_we_d    = i_req_we;
                        wb_addr_d  = {i_req_addr[31:2], 2'b00};
                        wb_sel_d   = align_sel;
                        wb_wdata_d = align_wdata;
                        state_d    = BUS;
`ifdef WB_TIMEOUT_EN
                        cnt_d      = '0;
`endif
                    end
                end
            end
            BUS: begin
                if (i_wb_ack) begin
                    wb_cyc_d    = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = wb_we_q ? '0 : align_rdata;
                    state_d     = RESP;
                end
`ifdef WB_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                    wb_cyc_d    = 1'b0;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_WIDTH'(1);
                end
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= IDLE;
            off_q       <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            wb_cyc_q    <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_addr_q   <= '0;
            wb_sel_q    <= '0;
            wb_wdata_q  <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef WB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            wb_cyc_q    <= wb_cyc_d;
            wb_we_q     <= wb_we_d;
            wb_addr_q   <= wb_addr_d;
            wb_sel_q    <= wb_sel_d;
            wb_wdata_q  <= wb_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef WB_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign o_req_ready = (state_q == IDLE);
    assign o_rsp_valid = (state_q == RESP);
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_wb_cyc    = wb_cyc_q;
    assign o_wb_stb    = wb_cyc_q;
    assign o_wb_we     = wb_we_q;
    assign o_wb_addr   = wb_addr_q;
    assign o_wb_sel    = wb_sel_q;
    assign o_wb_wdata  = wb_wdata_q;

endmodule
